// File: rtl/ma_result_fifo.sv
// Result FIFO behind the moving-average filter: show-ahead valid/ready output,
// fill level, sticky overflow and a saturating drop counter.
module ma_result_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic                    in_valid,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    full,
    output logic                    overflow,
    output logic [7:0]              drop_cnt
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] LVL_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] LVL_FULL = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] LVL_ZERO = {(ADDR_W+1){1'b0}};

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [ADDR_W:0]       wr_ptr_r, rd_ptr_r, level_r;
    logic [ADDR_W:0]       wr_ptr_nxt_s, rd_ptr_nxt_s, level_nxt_s;
    logic                  out_valid_r, full_r, overflow_r;
    logic                  out_valid_nxt_s, full_nxt_s, overflow_nxt_s;
    logic [7:0]            drop_cnt_r, drop_cnt_nxt_s;
    logic                  pop_s, push_s, drop_s, mem_we_s;

    // Handshake decode and next-state computation; clear overrides push and pop.
    always_comb begin
        pop_s           = out_valid_r && out_ready;
        push_s          = in_valid && (!full_r || pop_s);
        drop_s          = in_valid && full_r && !pop_s;
        mem_we_s        = push_s && !clear;
        wr_ptr_nxt_s    = wr_ptr_r;
        rd_ptr_nxt_s    = rd_ptr_r;
        level_nxt_s     = level_r;
        overflow_nxt_s  = overflow_r;
        drop_cnt_nxt_s  = drop_cnt_r;
        if (clear) begin
            wr_ptr_nxt_s   = LVL_ZERO;
            rd_ptr_nxt_s   = LVL_ZERO;
            level_nxt_s    = LVL_ZERO;
            overflow_nxt_s = 1'b0;
            drop_cnt_nxt_s = 8'd0;
        end else begin
            if (push_s) begin
                wr_ptr_nxt_s = wr_ptr_r + LVL_ONE;
            end else begin
                wr_ptr_nxt_s = wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_nxt_s = rd_ptr_r + LVL_ONE;
            end else begin
                rd_ptr_nxt_s = rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   level_nxt_s = level_r + LVL_ONE;
                2'b01:   level_nxt_s = level_r - LVL_ONE;
                default: level_nxt_s = level_r;
            endcase
            if (drop_s) begin
                overflow_nxt_s = 1'b1;
                if (drop_cnt_r != 8'hFF) begin
                    drop_cnt_nxt_s = drop_cnt_r + 8'd1;
                end else begin
                    drop_cnt_nxt_s = drop_cnt_r;
                end
            end else begin
                overflow_nxt_s = overflow_r;
                drop_cnt_nxt_s = drop_cnt_r;
            end
        end
        // Flags are registered from the next level so they never see in_valid/out_ready combinationally.
        out_valid_nxt_s = (level_nxt_s != LVL_ZERO);
        full_nxt_s      = (level_nxt_s == LVL_FULL);
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r    <= LVL_ZERO;
            rd_ptr_r    <= LVL_ZERO;
            level_r     <= LVL_ZERO;
            out_valid_r <= 1'b0;
            full_r      <= 1'b0;
            overflow_r  <= 1'b0;
            drop_cnt_r  <= 8'd0;
        end else begin
            wr_ptr_r    <= wr_ptr_nxt_s;
            rd_ptr_r    <= rd_ptr_nxt_s;
            level_r     <= level_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            full_r      <= full_nxt_s;
            overflow_r  <= overflow_nxt_s;
            drop_cnt_r  <= drop_cnt_nxt_s;
        end
    end

    // Sample storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[wr_ptr_r[ADDR_W-1:0]] <= in_data;
        end
    end

    assign out_data  = out_valid_r ? mem_r[rd_ptr_r[ADDR_W-1:0]] : {DATA_WIDTH{1'b0}};
    assign out_valid = out_valid_r;
    assign level     = level_r;
    assign full      = full_r;
    assign overflow  = overflow_r;
    assign drop_cnt  = drop_cnt_r;

endmodule

// File: tb/tb_ma_result_fifo.sv
// Directed and randomised self-checking bench for ma_result_fifo (DEPTH=8).
module tb_ma_result_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic [15:0] in_data;
    logic        in_valid;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  level;
    logic        full;
    logic        overflow;
    logic [7:0]  drop_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    ma_result_fifo #(.DATA_WIDTH(16), .DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_data(in_data), .in_valid(in_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .level(level), .full(full), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 16'h0000;
        tick(); tick();
        tests_run++;
        if ({out_valid, level, full, overflow, drop_cnt, out_data} !== {1'b0, 4'd0, 1'b0, 1'b0, 8'd0, 16'h0000}) begin
            tests_failed++;
            $display("FAIL reset: valid=%0b level=%0d full=%0b ovf=%0b drop=%0d data=%h, want all 0",
                     out_valid, level, full, overflow, drop_cnt, out_data);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_ordering();
        logic [15:0] exp [3];
        exp[0] = 16'h0005; exp[1] = 16'hFFFD; exp[2] = 16'h7FFF;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = exp[i];
            tick();
        end
        in_valid = 1'b0;
        tests_run++;
        if (level !== 4'd3) begin
            tests_failed++;
            $display("FAIL ordering_level: got %0d want 3", level);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== exp[i]) begin
                tests_failed++;
                $display("FAIL ordering_pop%0d: valid=%0b data=%h want 1/%h", i, out_valid, out_data, exp[i]);
            end
            tick();
        end
        out_ready = 1'b0;
        tests_run++;
        if (level !== 4'd0 || out_valid !== 1'b0 || out_data !== 16'h0000) begin
            tests_failed++;
            $display("FAIL ordering_empty: level=%0d valid=%0b data=%h want 0/0/0", level, out_valid, out_data);
        end
    endtask

    task automatic drain_check(input string nm, input int first, input int last);
        out_ready = 1'b1;
        for (int v = first; v <= last; v++) begin
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== 16'(v)) begin
                tests_failed++;
                $display("FAIL %s_drain: valid=%0b data=%0d want 1/%0d", nm, out_valid, out_data, v);
            end
            tick();
        end
        out_ready = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || level !== 4'd0) begin
            tests_failed++;
            $display("FAIL %s_drained: valid=%0b level=%0d want 0/0", nm, out_valid, level);
        end
    endtask

    task automatic test_overflow();
        do_clear();
        for (int v = 1; v <= 10; v++) begin
            in_valid = 1'b1; in_data = 16'(v);
            tick();
        end
        in_valid = 1'b0;
        tests_run++;
        if (full !== 1'b1 || level !== 4'd8 || overflow !== 1'b1 || drop_cnt !== 8'd2) begin
            tests_failed++;
            $display("FAIL overflow: full=%0b level=%0d ovf=%0b drop=%0d want 1/8/1/2", full, level, overflow, drop_cnt);
        end
        drain_check("overflow", 1, 8);
    endtask

    task automatic test_full_push_pop();
        do_clear();
        for (int v = 1; v <= 8; v++) begin
            in_valid = 1'b1; in_data = 16'(v);
            tick();
        end
        in_valid = 1'b1; in_data = 16'd9; out_ready = 1'b1;
        tests_run++;
        if (out_data !== 16'd1 || full !== 1'b1) begin
            tests_failed++;
            $display("FAIL fullpp_head: data=%0d full=%0b want 1/1", out_data, full);
        end
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        tests_run++;
        if (level !== 4'd8 || overflow !== 1'b0 || drop_cnt !== 8'd0) begin
            tests_failed++;
            $display("FAIL fullpp_level: level=%0d ovf=%0b drop=%0d want 8/0/0", level, overflow, drop_cnt);
        end
        drain_check("fullpp", 2, 9);
    endtask

    task automatic test_saturation_clear();
        do_clear();
        for (int v = 0; v < 308; v++) begin
            in_valid = 1'b1; in_data = 16'(v);
            tick();
        end
        in_valid = 1'b0;
        tests_run++;
        if (drop_cnt !== 8'd255 || overflow !== 1'b1 || level !== 4'd8) begin
            tests_failed++;
            $display("FAIL saturation: drop=%0d ovf=%0b level=%0d want 255/1/8", drop_cnt, overflow, level);
        end
        clear = 1'b1; in_valid = 1'b1; in_data = 16'h1234;
        tick();
        clear = 1'b0; in_valid = 1'b0;
        tests_run++;
        if (level !== 4'd0 || drop_cnt !== 8'd0 || overflow !== 1'b0 || out_valid !== 1'b0 || full !== 1'b0) begin
            tests_failed++;
            $display("FAIL clear: level=%0d drop=%0d ovf=%0b valid=%0b full=%0b want all 0",
                     level, drop_cnt, overflow, out_valid, full);
        end
    endtask

    task automatic test_async_reset();
        for (int v = 1; v <= 3; v++) begin
            in_valid = 1'b1; in_data = 16'(v);
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (level !== 4'd0 || out_valid !== 1'b0 || out_data !== 16'h0000) begin
            tests_failed++;
            $display("FAIL async_reset: level=%0d valid=%0b data=%h want 0/0/0", level, out_valid, out_data);
        end
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tests_run++;
        if (level !== 4'd0 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset_after: level=%0d valid=%0b want 0/0", level, out_valid);
        end
    endtask

    task automatic test_random_wrap();
        logic [15:0] q[$];
        int          exp_drops = 0;
        bit          exp_ovf = 1'b0;
        bit          iv, ordy, m_pop, m_push;
        int          p_in, p_out;
        int          shown = 0;
        do_clear();
        for (int c = 0; c < 10000; c++) begin
            p_in  = ((c / 1000) % 3 == 0) ? 80 : (((c / 1000) % 3 == 1) ? 30 : 55);
            p_out = ((c / 1000) % 3 == 0) ? 30 : (((c / 1000) % 3 == 1) ? 80 : 55);
            iv   = ($urandom_range(0, 99) < p_in);
            ordy = ($urandom_range(0, 99) < p_out);
            in_valid = iv; out_ready = ordy; in_data = 16'($urandom);
            tests_run++;
            if (out_valid !== (q.size() != 0) ||
                (q.size() != 0 && out_data !== q[0]) || (q.size() == 0 && out_data !== 16'h0000)) begin
                tests_failed++;
                if (shown < 20) begin
                    shown++;
                    $display("FAIL random_head c=%0d: valid=%0b data=%h want %0b/%h",
                             c, out_valid, out_data, q.size() != 0, (q.size() != 0) ? q[0] : 16'h0000);
                end
            end
            m_pop  = (q.size() != 0) && ordy;
            m_push = iv && (q.size() < 8 || m_pop);
            if (iv && q.size() == 8 && !m_pop) begin
                exp_ovf = 1'b1;
                if (exp_drops < 255) exp_drops++;
            end
            tick();
            if (m_pop) void'(q.pop_front());
            if (m_push) q.push_back(in_data);
            tests_run++;
            if (level !== 4'(q.size()) || full !== (q.size() == 8) ||
                overflow !== exp_ovf || drop_cnt !== 8'(exp_drops)) begin
                tests_failed++;
                if (shown < 20) begin
                    shown++;
                    $display("FAIL random_state c=%0d: level=%0d full=%0b ovf=%0b drop=%0d want %0d/%0b/%0b/%0d",
                             c, level, full, overflow, drop_cnt, q.size(), q.size() == 8, exp_ovf, exp_drops);
                end
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ordering();
        test_overflow();
        test_full_push_pop();
        test_saturation_clear();
        test_async_reset();
        test_random_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
